// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Constants and types shared by the operand sequencer, ALU and display:
// keypad codes, operator encodings and the sequencer state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package calc_pkg;

    // Keypad codes that the sequencer reacts to; 0-9 are digits handled upstream.
    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_CLR = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hF;

    // Operator encoding presented to the arithmetic stage; 10/11 are reserved.
    typedef logic [1:0] opcode_t;
    localparam opcode_t OP_ADD = 2'b00;
    localparam opcode_t OP_SUB = 2'b01;

    // Three bits wide so the display can show the state directly.
    typedef enum logic [2:0] {
        ST_ENTER_A  = 3'd0,
        ST_ENTER_B  = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_ERROR    = 3'd3
    } state_t;

    function automatic logic is_operator(input logic [3:0] key);
        return (key == KEY_ADD) || (key == KEY_SUB);
    endfunction

endpackage

// File: rtl/operand_sequencer_if.sv
// ---------------------------------------------------------------------------
// operand_sequencer_if
// Groups the keypad inputs, the operand bus and the {A, op, B} result
// bundle with its valid/ack handshake.
//   master : the sequencer (drives opA/opB/opcode/op_valid/err/entry_clr/state)
//   slave  : input unit + arithmetic stage (drives trig/value/B_in/OUT_Range/op_ack)
// Parameter WIDTH : operand width in bits.
// ---------------------------------------------------------------------------
interface operand_sequencer_if #(
    parameter int WIDTH = 8
);
    import calc_pkg::*;

    logic             trig;       // key-held level from the scanner
    logic [3:0]       value;      // key code, stable while trig is high
    logic [WIDTH-1:0] B_in;       // current operand from the input unit
    logic             OUT_Range;  // current entry is out of range
    logic             op_ack;     // consumer accepted the bundle
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    opcode_t          opcode;
    logic             op_valid;
    logic             err;
    logic             entry_clr;  // one-cycle clear to the digit buffer
    logic [2:0]       state;

    modport master (
        input  trig, value, B_in, OUT_Range, op_ack,
        output opA, opB, opcode, op_valid, err, entry_clr, state
    );

    modport slave (
        output trig, value, B_in, OUT_Range, op_ack,
        input  opA, opB, opcode, op_valid, err, entry_clr, state
    );

endinterface

// File: rtl/key_press_detect.sv
// ---------------------------------------------------------------------------
// key_press_detect
// Turns the key-held level into a single-cycle press indication on the
// first cycle the key is seen down; a held key gives exactly one press.
// Ports:
//   clock  : system clock, rising edge
//   Reset  : asynchronous, active-high reset
//   trig   : key-held level
//   press  : high for the one cycle where trig is high and was low before
// ---------------------------------------------------------------------------
module key_press_detect (
    input  logic clock,
    input  logic Reset,
    input  logic trig,
    output logic press
);

    logic trig_q;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples its inputs as they were before the edge.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) trig_q <= 1'b0;
        else       trig_q <= trig;
    end

    // Combinational so the action happens on the first edge trig is high.
    assign press = trig & ~trig_q;

endmodule

// File: rtl/operand_sequencer.sv
// ---------------------------------------------------------------------------
// operand_sequencer
// Captures operand A on an operator key, operand B on equals, and holds the
// {A, op, B} bundle valid until the arithmetic stage acknowledges it.
// Out-of-range entries latch err until the clear key; entry_clr tells the
// input unit to empty its digit buffer between operands.
// Parameters:
//   WIDTH          : operand width
//   TIMEOUT_CYCLES : idle cycles before automatic clear (ENTRY_TIMEOUT_EN only)
// Ports:
//   clock, Reset   : rising-edge clock, asynchronous active-high reset
//   bus            : operand_sequencer_if.master (keys, operand, bundle, status)
// Build option:
//   ENTRY_TIMEOUT_EN : when defined, ENTER_B and ERROR clear themselves after
//                      TIMEOUT_CYCLES cycles without a key press.
// ---------------------------------------------------------------------------
module operand_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic                 clock,
    input  logic                 Reset,
    operand_sequencer_if.master  bus
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t           state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    opcode_t          opcode_q;
    logic             op_valid_q;
    logic             err_q;
    logic             entry_clr_q;

    logic press;
    logic timeout_hit;
    logic clear_req;

    key_press_detect u_press (
        .clock (clock),
        .Reset (Reset),
        .trig  (bus.trig),
        .press (press)
    );

`ifdef ENTRY_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] idle_cnt;

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset)
            idle_cnt <= '0;
        else if (press || state_q == ST_WAIT_ACK || timeout_hit)
            idle_cnt <= '0;
        else if (idle_cnt != CNT_W'(TIMEOUT_CYCLES))
            idle_cnt <= idle_cnt + 1'b1;
    end

    // Fires on the edge the count reaches TIMEOUT_CYCLES; a press wins.
    assign timeout_hit = !press
                      && (state_q == ST_ENTER_B || state_q == ST_ERROR)
                      && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Clear outranks everything else, including a same-cycle op_ack.
    assign clear_req = (press && bus.value == KEY_CLR) || timeout_hit;

    // Each pulse site writes !entry_clr_q, so a pulse requested right after
    // another (e.g. a key press just after a timeout clear) is merged and
    // entry_clr is never high on two consecutive cycles.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_ENTER_A;
            opa_q       <= '0;
            opb_q       <= '0;
            opcode_q    <= OP_ADD;
            op_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            entry_clr_q <= 1'b0;
        end else begin
            entry_clr_q <= 1'b0;
            if (clear_req) begin
                state_q     <= ST_ENTER_A;
                opa_q       <= '0;
                opb_q       <= '0;
                opcode_q    <= OP_ADD;
                op_valid_q  <= 1'b0;
                err_q       <= 1'b0;
                entry_clr_q <= !entry_clr_q;
            end else begin
                case (state_q)
                    ST_ENTER_A: begin
                        if (press && is_operator(bus.value)) begin
                            if (bus.OUT_Range) begin
                                err_q   <= 1'b1;
                                state_q <= ST_ERROR;
                            end else begin
                                opa_q       <= bus.B_in;
                                opcode_q    <= (bus.value == KEY_SUB) ? OP_SUB : OP_ADD;
                                entry_clr_q <= !entry_clr_q;
                                state_q     <= ST_ENTER_B;
                            end
                        end
                    end
                    ST_ENTER_B: begin
                        if (press && bus.value == KEY_EQ) begin
                            if (bus.OUT_Range) begin
                                err_q   <= 1'b1;
                                state_q <= ST_ERROR;
                            end else begin
                                opb_q      <= bus.B_in;
                                op_valid_q <= 1'b1;
                                state_q    <= ST_WAIT_ACK;
                            end
                        end
                    end
                    ST_WAIT_ACK: begin
                        // Operands and opcode stay put for the display.
                        if (bus.op_ack) begin
                            op_valid_q  <= 1'b0;
                            entry_clr_q <= !entry_clr_q;
                            state_q     <= ST_ENTER_A;
                        end
                    end
                    default: ;  // ST_ERROR: only a clear leaves
                endcase
            end
        end
    end

    assign bus.opA       = opa_q;
    assign bus.opB       = opb_q;
    assign bus.opcode    = opcode_q;
    assign bus.op_valid  = op_valid_q;
    assign bus.err       = err_q;
    assign bus.entry_clr = entry_clr_q;
    assign bus.state     = state_q;

endmodule
